// File: rtl/quarter_cycle_delay.sv
`default_nettype none
// ============================================================================
// Module   : quarter_cycle_delay
// Purpose  : 90-degree (DELAY-sample) phase delay with time-aligned direct
//            sample output. Optional macro QUAD_NEGATE_EN makes Vq the
//            saturating negation of the delayed sample.
// Revision : 1.0 - initial release
// ============================================================================
module quarter_cycle_delay #(
    parameter int WIDTH = 14,
    parameter int DELAY = 40,
    parameter int AW    = 6
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    sample_en,
    input  logic signed [WIDTH-1:0] Vin,
    output logic signed [WIDTH-1:0] Vdir,
    output logic signed [WIDTH-1:0] Vq,
    output logic                    out_valid,
    output logic                    filled
);

    localparam logic [0:0]    S_FILL = 1'b0;
    localparam logic [0:0]    S_RUN  = 1'b1;
    localparam logic [AW-1:0] c_LAST = AW'(DELAY - 1);

    logic [WIDTH-1:0]        r_mem [0:DELAY-1];
    logic [AW-1:0]           r_ptr;
    logic [AW-1:0]           r_fcnt;
    logic [0:0]              r_state;
    logic signed [WIDTH-1:0] r_vdir;
    logic signed [WIDTH-1:0] r_vq;
    logic                    r_valid;
    logic                    r_filled;

    logic signed [WIDTH-1:0] w_rd;
    logic signed [WIDTH-1:0] w_qnext;

    assign w_rd = r_mem[r_ptr];

`ifdef QUAD_NEGATE_EN
    localparam logic signed [WIDTH-1:0] c_MIN = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic signed [WIDTH-1:0] c_MAX = {1'b0, {(WIDTH-1){1'b1}}};

    // The most negative code has no positive twin; clamp it to full scale.
    assign w_qnext = (w_rd == c_MIN) ? c_MAX : -w_rd;
`else
    assign w_qnext = w_rd;
`endif

    // Buffer is never cleared; the fill state machine masks stale contents.
    always_ff @(posedge clk) begin
        if (sample_en && !rst) begin
            r_mem[r_ptr] <= Vin;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr    <= '0;
            r_fcnt   <= '0;
            r_state  <= S_FILL;
            r_vdir   <= '0;
            r_vq     <= '0;
            r_valid  <= 1'b0;
            r_filled <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (sample_en) begin
                r_ptr <= (r_ptr == c_LAST) ? '0 : r_ptr + 1'b1;
                case (r_state)
                    S_FILL: begin
                        if (r_fcnt == c_LAST) begin
                            r_state  <= S_RUN;
                            r_filled <= 1'b1;
                        end else begin
                            r_fcnt <= r_fcnt + 1'b1;
                        end
                    end
                    S_RUN: begin
                        r_vdir  <= Vin;
                        r_vq    <= w_qnext;
                        r_valid <= 1'b1;
                    end
                    default: r_state <= S_FILL;
                endcase
            end
        end
    end

    assign Vdir      = r_vdir;
    assign Vq        = r_vq;
    assign out_valid = r_valid;
    assign filled    = r_filled;

endmodule
`default_nettype wire

// File: tb/tb_quarter_cycle_delay.sv
`default_nettype none
// ============================================================================
// Module   : tb_quarter_cycle_delay
// Purpose  : Directed self-checking bench for quarter_cycle_delay (DELAY=40)
//            with a DELAY=1 companion instance.
// Revision : 1.0 - initial release
// ============================================================================
module tb_quarter_cycle_delay;

    localparam int WIDTH = 14;
    localparam int DLY   = 40;
    localparam int NRAMP = 200;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    sample_en = 1'b0;
    logic signed [WIDTH-1:0] vin = '0;
    logic signed [WIDTH-1:0] vdir, vq, vdir1, vq1;
    logic                    out_valid, filled, out_valid1, filled1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int vin;
        int vdir;
        int vq;
        bit valid;
        bit filled;
    } vec_t;

    vec_t ramp [NRAMP];
    int   hist [400];

    quarter_cycle_delay #(.WIDTH(WIDTH), .DELAY(DLY), .AW(6)) dut (
        .clk(clk), .rst(rst), .sample_en(sample_en), .Vin(vin),
        .Vdir(vdir), .Vq(vq), .out_valid(out_valid), .filled(filled)
    );

    quarter_cycle_delay #(.WIDTH(WIDTH), .DELAY(1), .AW(1)) dut1 (
        .clk(clk), .rst(rst), .sample_en(sample_en), .Vin(vin),
        .Vdir(vdir1), .Vq(vq1), .out_valid(out_valid1), .filled(filled1)
    );

    always #5 clk = ~clk;

    function automatic int qv(input int x);
`ifdef QUAD_NEGATE_EN
        return (x == -8192) ? 8191 : -x;
`else
        return x;
`endif
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input bit r, input bit en, input int v);
        rst       = r;
        sample_en = en;
        vin       = WIDTH'(v);
        @(posedge clk);
        #1;
    endtask

    task automatic check_outs(input string tag, input vec_t e);
        check({tag, " valid"},  int'(out_valid), int'(e.valid));
        check({tag, " filled"}, int'(filled),    int'(e.filled));
        check({tag, " vdir"},   int'(vdir),      e.vdir);
        check({tag, " vq"},     int'(vq),        e.vq);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 0);
        step(1'b1, 1'b0, 0);
    endtask

    initial begin
        // Ramp expectations: first valid at k=DLY, filled from k=DLY-1.
        for (int k = 0; k < NRAMP; k++) begin
            ramp[k].vin    = 100 + k;
            ramp[k].valid  = (k >= DLY);
            ramp[k].filled = (k >= DLY - 1);
            ramp[k].vdir   = (k >= DLY) ? 100 + k : 0;
            ramp[k].vq     = (k >= DLY) ? qv(100 + k - DLY) : 0;
        end

        // Reset state
        do_reset();
        check("rst valid",  int'(out_valid), 0);
        check("rst filled", int'(filled),    0);
        check("rst vdir",   int'(vdir),      0);
        check("rst vq",     int'(vq),        0);
        check("rst filled1", int'(filled1),  0);

        // Prime and ramp, strobe every cycle; DELAY=1 instance checked alongside
        for (int k = 0; k < NRAMP; k++) begin
            step(1'b0, 1'b1, ramp[k].vin);
            check_outs($sformatf("ramp k=%0d", k), ramp[k]);
            check("d1 filled", int'(filled1), 1);
            check("d1 valid",  int'(out_valid1), (k >= 1) ? 1 : 0);
            if (k >= 1) begin
                check("d1 vq",   int'(vq1),   qv(99 + k));
                check("d1 vdir", int'(vdir1), 100 + k);
            end
        end
        step(1'b0, 1'b0, 0);
        check("ramp idle valid", int'(out_valid), 0);
        check("ramp idle vdir",  int'(vdir), ramp[NRAMP-1].vdir);

        // Gapped strobes: same sequence, outputs hold between strobes
        do_reset();
        for (int k = 0; k < NRAMP; k++) begin
            step(1'b0, 1'b1, ramp[k].vin);
            check_outs($sformatf("gap k=%0d", k), ramp[k]);
            for (int g = 0; g < 4; g++) begin
                step(1'b0, 1'b0, 7777);
                check("gap hold valid", int'(out_valid), 0);
                check("gap hold vdir",  int'(vdir), ramp[k].vdir);
                check("gap hold vq",    int'(vq),   ramp[k].vq);
            end
        end

        // Sine wave: 160 samples per cycle, 10 pointer wraps
        do_reset();
        for (int n = 0; n < 400; n++) begin
            hist[n] = int'(8000.0 * $sin(2.0 * 3.14159265358979 * n / 160.0));
            step(1'b0, 1'b1, hist[n]);
            check("sine valid", int'(out_valid), (n >= DLY) ? 1 : 0);
            if (n >= DLY) begin
                check($sformatf("sine vq n=%0d", n), int'(vq), qv(hist[n - DLY]));
                check("sine vdir", int'(vdir), hist[n]);
            end
        end

        // Reset mid-run together with a strobe
        do_reset();
        for (int k = 0; k < 120; k++) step(1'b0, 1'b1, ramp[k].vin);
        step(1'b1, 1'b1, 999);
        check("midrst valid",  int'(out_valid), 0);
        check("midrst vq",     int'(vq),        0);
        check("midrst vdir",   int'(vdir),      0);
        check("midrst filled", int'(filled),    0);
        for (int j = 0; j <= DLY; j++) begin
            step(1'b0, 1'b1, 500 + j);
            check("post-rst valid",  int'(out_valid), (j == DLY) ? 1 : 0);
            check("post-rst filled", int'(filled),    (j >= DLY - 1) ? 1 : 0);
            check("post-rst vq",     int'(vq),        (j == DLY) ? qv(500) : 0);
        end
        check("post-rst vdir", int'(vdir), 500 + DLY);

        // Most negative code through the delay line
        do_reset();
        step(1'b0, 1'b1, -8192);
        for (int k = 1; k <= DLY; k++) step(1'b0, 1'b1, 0);
        check("minneg valid", int'(out_valid), 1);
        check("minneg vq",    int'(vq), qv(-8192));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
